// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: decode/execute/memory hazard
// inputs and the pipeline-register controls driven back into the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int RA_W = 4
);
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use1;
    logic            id_use2;
    logic [RA_W-1:0] ex_rd;
    logic            ex_wbs;
    logic            ex_mm;
    logic            mem_req;
    logic            br_taken;
    logic            pc_en;
    logic            fd_en;
    logic            fd_flush;
    logic            de_en;
    logic            de_bubble;
    logic            em_en;
    logic [1:0]      state;
    logic [15:0]     stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_wbs, ex_mm, mem_req, br_taken,
        input  pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, state, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_wbs, ex_mm, mem_req, br_taken,
        output pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, state, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// multi-cycle memory freezes, taken-branch flushes and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int RA_W            = 4,
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_FLUSH    = 2'b10;

    localparam int WCNT_W = $clog2(MEM_WAIT_CYCLES + 1);
    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(MEM_WAIT_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    logic [1:0]        state_reg, state_next;
    logic [1:0]        ret_reg, ret_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic [15:0]       stall_cnt_reg;

    logic [RA_W-1:0] rs1, rs2, rd;
    logic            load_use;
    logic            pc_en, fd_en, fd_flush, de_en, de_bubble, em_en;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    // r0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = bus.ex_mm & bus.ex_wbs & (rd != '0) &
                      ((bus.id_use1 & (rs1 == rd)) | (bus.id_use2 & (rs2 == rd)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            ret_reg   <= ST_RUN;
            wcnt_reg  <= '0;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            wcnt_reg  <= wcnt_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        wcnt_next  = wcnt_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            ST_MEM_WAIT: begin
                wcnt_next = wcnt_reg - WCNT_ONE;
                if (wcnt_reg <= WCNT_ONE) begin
                    state_next = ret_reg;
                end
            end
            ST_FLUSH: begin
                // A freeze inside a flush parks fcnt and resumes the flush afterwards.
                if (bus.mem_req) begin
                    if (MEM_WAIT_CYCLES > 1) begin
                        state_next = ST_MEM_WAIT;
                        wcnt_next  = WCNT_INIT;
                        ret_next   = ST_FLUSH;
                    end
                end else begin
                    fcnt_next = fcnt_reg - FCNT_ONE;
                    if (fcnt_reg <= FCNT_ONE) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                if (bus.mem_req) begin
                    if (MEM_WAIT_CYCLES > 1) begin
                        state_next = ST_MEM_WAIT;
                        wcnt_next  = WCNT_INIT;
                        ret_next   = ST_RUN;
                    end
                end else if (bus.br_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_next = ST_FLUSH;
                        fcnt_next  = FCNT_INIT;
                    end
                end
            end
        endcase
    end

    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_en     = 1'b1;
        de_bubble = 1'b0;
        em_en     = 1'b1;
        case (state_reg)
            ST_MEM_WAIT: begin
                {pc_en, fd_en, de_en, em_en} = 4'b0000;
            end
            ST_FLUSH: begin
                if (bus.mem_req) begin
                    {pc_en, fd_en, de_en, em_en} = 4'b0000;
                end else begin
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end
            end
            default: begin
                if (bus.mem_req) begin
                    {pc_en, fd_en, de_en, em_en} = 4'b0000;
                end else if (bus.br_taken) begin
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    de_bubble = 1'b1;
                end
            end
        endcase
        if (!rst_n) begin
            {pc_en, fd_en, de_en, em_en} = 4'b0000;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.fd_en     = fd_en;
    assign bus.fd_flush  = fd_flush;
    assign bus.de_en     = de_en;
    assign bus.de_bubble = de_bubble;
    assign bus.em_en     = em_en;
    assign bus.state     = state_reg;
    assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES 2 and 3) driven in
// lockstep, checked by vector table, hand sequences and a freeze/flush budget model.
module tb_pipeline_hazard_ctrl;
    localparam int RA_W = 4;
    localparam int MW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [RA_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use1 = 0, id_use2 = 0, ex_wbs = 0, ex_mm = 0, mem_req = 0, br_taken = 0;

    // {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, state[1:0], stall_cnt[15:0]}
    logic [23:0] obs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pipeline_hazard_ctrl_if #(.RA_W(RA_W)) bus ();
        assign bus.id_rs1   = id_rs1;
        assign bus.id_rs2   = id_rs2;
        assign bus.id_use1  = id_use1;
        assign bus.id_use2  = id_use2;
        assign bus.ex_rd    = ex_rd;
        assign bus.ex_wbs   = ex_wbs;
        assign bus.ex_mm    = ex_mm;
        assign bus.mem_req  = mem_req;
        assign bus.br_taken = br_taken;
        pipeline_hazard_ctrl #(
            .RA_W(RA_W), .MEM_WAIT_CYCLES(MW), .FLUSH_CYCLES(gi == 0 ? 2 : 3)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign obs[gi] = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_en, bus.de_bubble,
                          bus.em_en, bus.state, bus.stall_cnt};
    end

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Model: outstanding frozen cycles, outstanding flush cycles, stall count.
    int frz [2] = '{0, 0};
    int fl  [2] = '{0, 0};
    int stl [2] = '{0, 0};
    logic [23:0] act [2];

    function automatic int flc(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic step(input bit do_chk);
        bit lu;
        logic [5:0] ctl;
        logic [1:0] st;
        int nst;
        @(negedge clk);
        lu = ex_mm && ex_wbs && (ex_rd != 0) &&
             ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
        for (int k = 0; k < 2; k++) begin
            st = (frz[k] > 0) ? 2'b01 : ((fl[k] > 0) ? 2'b10 : 2'b00);
            nst = stl[k];
            if (!rst_n) begin
                ctl = 6'b001010; frz[k] = 0; fl[k] = 0;
            end else if (frz[k] > 0) begin
                ctl = 6'b000000; frz[k] = frz[k] - 1;
            end else if (mem_req) begin
                ctl = 6'b000000; frz[k] = MW - 1;
            end else if (fl[k] > 0) begin
                ctl = 6'b111111; fl[k] = fl[k] - 1;
            end else if (br_taken) begin
                ctl = 6'b111111; fl[k] = flc(k) - 1;
            end else if (lu) begin
                ctl = 6'b000111;
            end else begin
                ctl = 6'b110101;
            end
            if (!rst_n) nst = 0;
            else if (!ctl[5] && stl[k] < 65535) nst = stl[k] + 1;
            act[k] = obs[k];
            if (do_chk) check($sformatf("model_dut%0d_cyc%0d", k, cyc), 32'(obs[k]),
                              32'({ctl, st, 16'(stl[k])}));
            stl[k] = nst;
        end
        if (do_chk)
            $display("cyc %0d rst_n=%b mem=%b br=%b lu=%b | dut0=%h dut1=%h",
                     cyc, rst_n, mem_req, br_taken, lu, act[0], act[1]);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; mem_req = 0; br_taken = 0; id_use1 = 0; id_use2 = 0;
        ex_mm = 0; ex_wbs = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    endtask

    task automatic set_lu();
        ex_mm = 1; ex_wbs = 1; ex_rd = 4'd3; id_rs2 = 4'd3; id_use2 = 1; id_use1 = 0;
    endtask

    task automatic settle();
        set_idle();
        for (int i = 0; i < 5; i++) step(1);
    endtask

    typedef struct {
        string      name;
        logic [3:0] rs1, rs2, rd;
        logic       use1, use2, wbs, mm;
        logic [5:0] ctl;
    } vec_t;
    vec_t tbl [8];

    initial begin
        logic [7:0] seq [7];
        logic [15:0] base;

        tbl[0] = '{"lu_rs2",   4'd1, 4'd3, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000111};
        tbl[1] = '{"rd_zero",  4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b110101};
        tbl[2] = '{"no_use2",  4'd1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110101};
        tbl[3] = '{"lu_rs1",   4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000111};
        tbl[4] = '{"no_wbs",   4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110101};
        tbl[5] = '{"no_mm",    4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 6'b110101};
        tbl[6] = '{"no_match", 4'd2, 4'd4, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 6'b110101};
        tbl[7] = '{"lu_both",  4'd9, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000111};

        // Reset held for 3 cycles under random inputs.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 4'($urandom); id_rs2 = 4'($urandom); ex_rd = 4'($urandom);
            {id_use1, id_use2, ex_wbs, ex_mm, mem_req, br_taken} = 6'($urandom);
            step(1);
            check($sformatf("reset_%0d", i), 32'(act[0]), 32'({6'b001010, 2'b00, 16'h0}));
        end
        set_idle();
        step(1);
        check("post_reset", 32'(act[0][23:16]), 32'({6'b110101, 2'b00}));

        // Single-cycle decode/execute combinations from RUN.
        for (int i = 0; i < 8; i++) begin
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
            id_use1 = tbl[i].use1; id_use2 = tbl[i].use2;
            ex_wbs = tbl[i].wbs; ex_mm = tbl[i].mm;
            step(1);
            check(tbl[i].name, 32'(act[0][23:16]), 32'({tbl[i].ctl, 2'b00}));
        end

        // Load-use: one bubble and exactly one stall count.
        settle();
        set_lu();
        step(1);
        base = act[0][15:0];
        check("lu_bubble", 32'(act[0][23:16]), 32'({6'b000111, 2'b00}));
        set_idle();
        step(1);
        check("lu_release", 32'(act[0][23:16]), 32'({6'b110101, 2'b00}));
        check("lu_stall", 32'(act[0][15:0]), 32'(base + 16'd1));

        // Memory freeze of 3 cycles.
        settle();
        seq[0] = 8'b000000_00; seq[1] = 8'b000000_01; seq[2] = 8'b000000_01;
        seq[3] = 8'b110101_00;
        for (int i = 0; i < 4; i++) begin
            mem_req = (i == 0);
            step(1);
            if (i == 0) base = act[0][15:0];
            check($sformatf("memwait_%0d", i), 32'(act[0][23:16]), 32'(seq[i]));
        end
        check("memwait_stall", 32'(act[0][15:0]), 32'(base + 16'd3));

        // Branch flush, two cycles on instance 0.
        settle();
        seq[0] = 8'b111111_00; seq[1] = 8'b111111_10; seq[2] = 8'b110101_00;
        for (int i = 0; i < 3; i++) begin
            br_taken = (i == 0);
            step(1);
            check($sformatf("branch_%0d", i), 32'(act[0][23:16]), 32'(seq[i]));
        end

        // mem_req + br_taken + load_use together; branch held through the freeze.
        settle();
        seq[0] = 8'b000000_00; seq[1] = 8'b000000_01; seq[2] = 8'b000000_01;
        seq[3] = 8'b111111_00; seq[4] = 8'b111111_10; seq[5] = 8'b110101_00;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin set_lu(); br_taken = 1; end
            else set_idle();
            mem_req = (i == 0);
            step(1);
            check($sformatf("simul_%0d", i), 32'(act[0][23:16]), 32'(seq[i]));
        end

        // mem_req inside a 3-cycle flush on instance 1.
        settle();
        seq[0] = 8'b111111_00; seq[1] = 8'b111111_10; seq[2] = 8'b000000_10;
        seq[3] = 8'b000000_01; seq[4] = 8'b000000_01; seq[5] = 8'b111111_10;
        seq[6] = 8'b110101_00;
        for (int i = 0; i < 7; i++) begin
            br_taken = (i == 0);
            mem_req  = (i == 2);
            step(1);
            check($sformatf("flushmem_%0d", i), 32'(act[1][23:16]), 32'(seq[i]));
        end

        // Randomized traffic against the model.
        settle();
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            mem_req  = ($urandom_range(0, 7) == 0);
            br_taken = ($urandom_range(0, 7) == 0);
            id_rs1 = 4'($urandom_range(0, 3)); id_rs2 = 4'($urandom_range(0, 3));
            ex_rd  = 4'($urandom_range(0, 3));
            {id_use1, id_use2, ex_wbs, ex_mm} = 4'($urandom);
            step(1);
        end

        // Saturation via a long load-use stall.
        settle();
        set_lu();
        for (int i = 0; i < 65540; i++) step(0);
        for (int i = 0; i < 3; i++) step(1);
        check("sat_dut0", 32'(act[0][15:0]), 32'h0000FFFF);
        check("sat_dut1", 32'(act[1][15:0]), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
